// File: rtl/step_sequencer_pkg.sv
// rtl/step_sequencer_pkg.sv - opcode, ALU op, step index constants and instruction classes for step_sequencer
package step_sequencer_pkg;

    localparam int STEP_W = 7;

    localparam int S1 = 0;
    localparam int S2 = 1;
    localparam int S3 = 2;
    localparam int S4 = 3;
    localparam int S5 = 4;
    localparam int S6 = 5;
    localparam int S7 = 6;

    localparam logic [3:0] OPC_LD   = 4'h0;
    localparam logic [3:0] OPC_ST   = 4'h1;
    localparam logic [3:0] OPC_DATA = 4'h2;
    localparam logic [3:0] OPC_HALT = 4'h7;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_DATA,
        CLS_HALT
    } instr_cls_t;

    function automatic logic [3:0] reg_sel(input logic [1:0] idx);
        reg_sel = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/step_ring.sv
// rtl/step_ring.sv - one-hot seven-step ring counter with advance, freeze and asynchronous reset
module step_ring
    import step_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              freeze,
    output logic [STEP_W-1:0] step
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step <= 7'b0000001;
        end else if (advance && !freeze) begin
            step <= {step[STEP_W-2:0], step[STEP_W-1]};
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - seven-step control sequencer decoding ir into strobes; optional STEP_SEQUENCER_SINGLE_STEP_EN
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter logic [3:0] HALT_OPC = OPC_HALT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        ir,
`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic [STEP_W-1:0] step,
    output logic              halted,
    output logic              bus1,
    output logic              iar_e,
    output logic              mar_s,
    output logic              acc_s,
    output logic              acc_e,
    output logic              ir_s,
    output logic              iar_s,
    output logic              ram_e,
    output logic              ram_s,
    output logic              tmp_s,
    output logic [3:0]        reg_s,
    output logic [3:0]        reg_e,
    output logic [2:0]        alu_op
);

    instr_cls_t cls;
    logic       step_pulse;
    logic       active;
    logic       halt_hit;
    logic [3:0] ra_sel;
    logic [3:0] rb_sel;

`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
    logic step_req_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_req_q <= 1'b0;
        end else begin
            step_req_q <= step_req;
        end
    end

    assign step_pulse = step_req & ~step_req_q;
`else
    assign step_pulse = 1'b1;
`endif

    // Strobes exist only in a cycle that will actually close a step.
    assign active   = run & ~halted & ~reset & step_pulse;
    assign halt_hit = step[S4] & (cls == CLS_HALT);
    assign ra_sel   = reg_sel(ir[3:2]);
    assign rb_sel   = reg_sel(ir[1:0]);

    always_comb begin
        cls = CLS_NOP;
        if (ir[7]) begin
            cls = CLS_ALU;
        end else if (ir[7:4] == OPC_LD) begin
            cls = CLS_LD;
        end else if (ir[7:4] == OPC_ST) begin
            cls = CLS_ST;
        end else if (ir[7:4] == OPC_DATA) begin
            cls = CLS_DATA;
        end else if (ir[7:4] == HALT_OPC) begin
            cls = CLS_HALT;
        end
    end

    step_ring u_step_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (active),
        .freeze  (halt_hit),
        .step    (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (active && halt_hit) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        bus1   = 1'b0;
        iar_e  = 1'b0;
        mar_s  = 1'b0;
        acc_s  = 1'b0;
        acc_e  = 1'b0;
        ir_s   = 1'b0;
        iar_s  = 1'b0;
        ram_e  = 1'b0;
        ram_s  = 1'b0;
        tmp_s  = 1'b0;
        reg_s  = 4'b0000;
        reg_e  = 4'b0000;
        alu_op = ALU_ADD;
        if (active) begin
            // DATA reuses the fetch increment in step 4 to step IAR past its operand byte.
            if (step[S1] || (step[S4] && cls == CLS_DATA)) begin
                bus1   = 1'b1;
                iar_e  = 1'b1;
                mar_s  = 1'b1;
                acc_s  = 1'b1;
                alu_op = ALU_ADD;
            end else if (step[S2]) begin
                ram_e = 1'b1;
                ir_s  = 1'b1;
            end else if (step[S3]) begin
                acc_e = 1'b1;
                iar_s = 1'b1;
            end else if (step[S4]) begin
                case (cls)
                    CLS_ALU: begin
                        reg_e = rb_sel;
                        tmp_s = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        reg_e = ra_sel;
                        mar_s = 1'b1;
                    end
                    default: ;
                endcase
            end else if (step[S5]) begin
                case (cls)
                    CLS_ALU: begin
                        reg_e  = ra_sel;
                        acc_s  = 1'b1;
                        alu_op = ir[6:4];
                    end
                    CLS_LD, CLS_DATA: begin
                        ram_e = 1'b1;
                        reg_s = rb_sel;
                    end
                    CLS_ST: begin
                        reg_e = rb_sel;
                        ram_s = 1'b1;
                    end
                    default: ;
                endcase
            end else if (step[S6]) begin
                if (cls == CLS_ALU && ir[6:4] != ALU_CMP) begin
                    acc_e = 1'b1;
                    reg_s = rb_sel;
                end else if (cls == CLS_DATA) begin
                    acc_e = 1'b1;
                    iar_s = 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter HALT_OPC, default 4'h7, meaning ir[7:4] code decoded as HALT.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports listed in REQ-003..REQ-011.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  1 = sequencer advances; 0 = frozen.
REQ-006 ir  input  8  current instruction register contents.
REQ-007 step  output  7  one-hot current step, step[0] = step 1.
REQ-008 halted  output  1  HALT executed; sticky until reset.
REQ-009 bus1, iar_e, mar_s, acc_s, acc_e, ir_s, iar_s, ram_e, ram_s, tmp_s  output  1 each  register set/enable strobes.
REQ-010 reg_s, reg_e  output  4 each  one-hot set/enable for general registers R0..R3.
REQ-011 alu_op  output  3  ALU operation select.

Function
REQ-012 Each step SHALL last exactly one clk cycle while run=1; step 7 SHALL be followed by step 1.
REQ-013 Strobes SHALL be combinational decodes of step and ir, valid for the full step cycle; the target register captures on the closing clk edge.
REQ-014 Step 1 SHALL assert bus1, iar_e, mar_s, acc_s, with alu_op=3'b000 (ADD, IAR+1).
REQ-015 Step 2 SHALL assert ram_e, ir_s. Step 3 SHALL assert acc_e, iar_s.
REQ-016 Decoding: ir[7]=1 ALU (op=ir[6:4], RA=ir[3:2], RB=ir[1:0]); ir[7:4]=0000 LD; 0001 ST; 0010 DATA; HALT_OPC HALT; any other code is a NOP (steps 4-6 idle).
REQ-017 ALU: step 4 SHALL assert reg_e[RB], tmp_s; step 5 SHALL assert reg_e[RA], acc_s, alu_op=ir[6:4]; step 6 SHALL assert acc_e, reg_s[RB], except op=3'b111 (CMP), where step 6 is idle.
REQ-018 LD: step 4 SHALL assert reg_e[RA], mar_s; step 5 SHALL assert ram_e, reg_s[RB].
REQ-019 ST: step 4 SHALL assert reg_e[RA], mar_s; step 5 SHALL assert reg_e[RB], ram_s.
REQ-020 DATA: step 4 SHALL assert the step-1 strobe set (REQ-014); step 5 SHALL assert ram_e, reg_s[RB]; step 6 SHALL assert acc_e, iar_s.
REQ-021 Step 7 SHALL assert no strobes.
REQ-022 HALT in step 4 SHALL set halted on that edge and freeze step at step 4.
REQ-023 While halted=1, all strobes SHALL be 0.
REQ-024 run=0 SHALL hold step, force all strobes and alu_op to 0, and lose no state; resuming SHALL continue from the held step.
REQ-025 At most one reg_e bit and at most one bus-driving enable (iar_e, acc_e, ram_e, reg_e) SHALL be active in any cycle.

Reset
REQ-026 reset SHALL immediately force step=7'b0000001 and halted=0, including mid-instruction.
REQ-027 While reset=1, all strobes and alu_op SHALL be 0.
REQ-028 After reset deasserts, the first clk edge with run=1 SHALL complete step 1.

Configuration
REQ-029 Macro STEP_SEQUENCER_SINGLE_STEP_EN, when defined, SHALL add input step_req (1 bit); step advances only on a cycle with run=1 and a rising edge of step_req, detected by a registered sample. Strobes SHALL be asserted only in that advancing cycle.
REQ-030 Without the macro, step_req SHALL be absent and REQ-012 timing applies unchanged.

Structure
REQ-031 A shared package/header SHALL hold opcode constants (LD, ST, DATA, HALT), ALU op codes (ADD=000, CMP=111), and step-index constants.
REQ-032 The step ring counter SHALL be a sub-module, step_ring, covering reset, advance, freeze and wrap; decode SHALL stay in step_sequencer.

Verification
REQ-033 Reset, then run=1 for 7 clocks with ir=8'h00 -> step sequence 1..7 then 1; mar_s=1 only in steps 1 and 4.
REQ-034 ir=8'b1000_0110 (ADD, RA=R1, RB=R2) -> step 4 reg_e=0100 with tmp_s=1; step 5 reg_e=0010, alu_op=000; step 6 reg_s=0100.
REQ-035 ir=8'b1111_0001 (CMP) -> step 6 reg_s=0000 and acc_e=0.
REQ-036 ir=8'h70 -> halted=1 after step 4; step stays 0001000 for 20 clocks; all strobes 0; reset clears halted.
REQ-037 run=0 during step 5 of an ST for 5 clocks -> step held and ram_s=0; run=1 -> ram_s=1 for one cycle.
REQ-038 reset pulsed mid-step 5 between clock edges -> step=0000001 immediately, with no clk edge required.
